// File: rtl/serial_pattern_pkg.sv
// Shared definitions for the serial pattern detector: FSM state type and
// default sizing constants.
package serial_pattern_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int         DEFAULT_N       = 4;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
    localparam int         DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/bit_shift_reg.sv
// Serial-in / parallel-out history register; newest bit enters at the LSB.
// A synchronous clear wins over a shift on the same edge.
module bit_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (shift_en) begin
            q_d = {q_q[WIDTH-2:0], din};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/serial_pattern_detector.sv
// Overlapping serial pattern detector with fill tracking, registered match
// pulse and a saturating detection counter.
module serial_pattern_detector
    import serial_pattern_pkg::*;
#(
    parameter int             N       = DEFAULT_N,
    parameter logic [N-1:0]   PATTERN = N'(DEFAULT_PATTERN),
    parameter int             CNT_W   = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clear,
    output logic [N-1:0]     history,
    output logic             armed,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    localparam int                FILL_W    = $clog2(N + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              armed_q, armed_d;
    logic              match_q, match_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [N-1:0]      hist;
    logic [N-1:0]      hist_next;

    bit_shift_reg #(
        .WIDTH (N)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .shift_en (din_valid),
        .clr      (clear),
        .din      (din),
        .q        (hist)
    );

    // Compare against the window as it will look after this edge's shift.
    assign hist_next = {hist[N-2:0], din};

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        count_d = count_q;
        match_d = 1'b0;
        if (clear) begin
            state_d = FILL;
            fill_d  = '0;
            count_d = '0;
        end else if (din_valid) begin
            if (state_q == FILL) begin
                fill_d = fill_q + 1'b1;
                if (fill_q == FILL_LAST) begin
                    state_d = RUN;
                end
            end
            if (((state_q == RUN) || (fill_q == FILL_LAST)) && (hist_next == PATTERN)) begin
                match_d = 1'b1;
                if (count_q != CNT_MAX) begin
                    count_d = count_q + 1'b1;
                end
            end
        end
        armed_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            fill_q  <= '0;
            armed_q <= 1'b0;
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
            match_q <= match_d;
            count_q <= count_d;
        end
    end

    assign history     = hist;
    assign armed       = armed_q;
    assign match       = match_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed plus randomized bench for serial_pattern_detector (N=4, 1011,
// narrow 2-bit counter so saturation is reachable) with a scoreboard queue.
module tb_serial_pattern_detector;

    localparam int         N     = 4;
    localparam logic [3:0] PAT   = 4'b1011;
    localparam int         CNT_W = 2;
    localparam int         CMAX  = 3;

    typedef struct {
        logic       match;
        logic [3:0] hist;
        logic       armed;
        logic [1:0] cnt;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             din_valid;
    logic             din;
    logic             clear;
    logic [N-1:0]     history;
    logic             armed;
    logic             match;
    logic [CNT_W-1:0] match_count;

    exp_t       sb_q[$];
    logic [3:0] m_hist;
    int         m_fill;
    int         m_cnt;
    int         passed;
    int         total;

    serial_pattern_detector #(
        .N       (N),
        .PATTERN (PAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .clear       (clear),
        .history     (history),
        .armed       (armed),
        .match       (match),
        .match_count (match_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_output();
        exp_t e;
        if (sb_q.size() == 0) begin
            total = total + 1;
            $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            check("match",       {7'd0, match},       {7'd0, e.match});
            check("history",     {4'd0, history},     {4'd0, e.hist});
            check("armed",       {7'd0, armed},       {7'd0, e.armed});
            check("match_count", {6'd0, match_count}, {6'd0, e.cnt});
        end
    endtask

    // Drive one edge worth of inputs, predict the outcome, then compare.
    task automatic apply_stimulus(input logic v, input logic b, input logic c);
        exp_t       e;
        logic [3:0] nh;
        @(negedge clk);
        din_valid = v;
        din       = b;
        clear     = c;
        e.match   = 1'b0;
        if (c) begin
            m_hist = 4'd0;
            m_fill = 0;
            m_cnt  = 0;
        end else if (v) begin
            nh      = {m_hist[2:0], b};
            e.match = ((m_fill + 1) >= N) && (nh == PAT);
            m_hist  = nh;
            if (m_fill < N) m_fill = m_fill + 1;
            if (e.match && (m_cnt < CMAX)) m_cnt = m_cnt + 1;
        end
        e.hist  = m_hist;
        e.armed = (m_fill >= N);
        e.cnt   = 2'(m_cnt);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic feed(input logic [31:0] bits, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b1, bits[n-1-i], 1'b0);
            for (int g = 0; g < gap; g++) begin
                apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
    endtask

    // Reset asserted and released between clock edges; outputs must clear at once.
    task automatic async_reset(input string tag);
        @(negedge clk);
        din_valid = 1'b0;
        clear     = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_history"}, {4'd0, history},     8'd0);
        check({tag, "_armed"},   {7'd0, armed},       8'd0);
        check({tag, "_match"},   {7'd0, match},       8'd0);
        check({tag, "_count"},   {6'd0, match_count}, 8'd0);
        m_hist = 4'd0;
        m_fill = 0;
        m_cnt  = 0;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        m_hist    = 4'd0;
        m_fill    = 0;
        m_cnt     = 0;
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = 1'b0;
        clear     = 1'b0;
        #1;
        check("reset_history", {4'd0, history},     8'd0);
        check("reset_armed",   {7'd0, armed},       8'd0);
        check("reset_match",   {7'd0, match},       8'd0);
        check("reset_count",   {6'd0, match_count}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic 1011 detection");
        feed(32'b1011, 4, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] overlapping stream");
        apply_stimulus(1'b0, 1'b0, 1'b1);
        feed(32'b1011011, 7, 0);

        $display("[TB] stream with valid gaps");
        apply_stimulus(1'b0, 1'b0, 1'b1);
        feed(32'b1011011, 7, 3);

        $display("[TB] counter saturation");
        apply_stimulus(1'b0, 1'b0, 1'b1);
        feed(32'b1011011011011011, 16, 0);

        $display("[TB] clear beats valid");
        apply_stimulus(1'b0, 1'b0, 1'b1);
        feed(32'b101, 3, 0);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        feed(32'b101, 3, 0);
        feed(32'b1, 1, 0);

        $display("[TB] async reset mid-stream");
        apply_stimulus(1'b0, 1'b0, 1'b1);
        feed(32'b101, 3, 0);
        async_reset("midrst");
        feed(32'b1, 1, 0);
        feed(32'b1011, 4, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 80; i++) begin
            apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 19) == 0));
        end

        check("scoreboard_drained", 8'(sb_q.size()), 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
